// File: rtl/iir_pkg.sv
// iir_pkg: sample widths, signed sample types and the round/saturate helper
// shared by the decimator output stage.
package iir_pkg;
    localparam int W  = 14;
    localparam int OW = 12;
    localparam int D  = W + 1 - OW;

    typedef logic signed [W:0]   sample_t;
    typedef logic signed [W+1:0] wide_t;

    function automatic logic signed [OW-1:0] sat_round(input wide_t value, input int d, input int ow);
        wide_t half, hi, lo, r;
        half = wide_t'(1) <<< (d - 1);
        hi   = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        lo   = -hi - wide_t'(1);
        // one extra bit of headroom keeps the rounding add from wrapping
        r    = (value + half) >>> d;
        r    = (r > hi) ? hi : (r < lo) ? lo : r;
        return r[OW-1:0];
    endfunction
endpackage

// File: rtl/iir_fifo_fwft.sv
// iir_fifo_fwft: pointer-based first-word-fall-through FIFO; the head reads as
// zero while empty, so dout only moves on a pop or a push into an empty FIFO.
module iir_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int OW    = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [OW-1:0]                din,
    input  logic                         pop,
    output logic [OW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [OW-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic          do_push, do_pop;

    assign empty   = level == '0;
    assign full    = level == FULL_LVL;
    assign do_pop  = pop && !empty;
    // a pop frees the slot a same-cycle push needs when full
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd    <= '0;
            wr    <= '0;
            level <= '0;
        end else begin
            rd    <= rd + AW'(do_pop);
            wr    <= wr + AW'(do_push);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
endmodule

// File: rtl/iir_decim_out.sv
// iir_decim_out: decimate by 2**LOG2R, round/saturate W+1 -> OW bits, buffer in a FWFT FIFO.
// Define IIR_DECIM_AVG_EN to average each frame instead of keeping its last sample.
module iir_decim_out
    import iir_pkg::*;
#(
    parameter int LOG2R = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [W:0]            x_in,
    input  logic                         in_valid,
    output logic [OW-1:0]                y_out,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         ovf_sticky,
    input  logic                         clr_ovf
);
    logic [LOG2R-1:0] phase;
    logic             dec, push, full, empty;
    logic [OW-1:0]    fmt;
    sample_t          v;

    assign dec = in_valid && (phase == {LOG2R{1'b1}});

`ifdef IIR_DECIM_AVG_EN
    logic signed [W+LOG2R:0] acc, sum, x_ext;
    assign x_ext = (W+LOG2R+1)'(x_in);
    // phase 0 starts a fresh frame, dropping the previous frame's total
    assign sum   = (phase == '0) ? x_ext : acc + x_ext;
    assign v     = sample_t'(sum >>> LOG2R);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc <= '0;
        else if (in_valid) acc <= sum;
    end
`else
    assign v = x_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= '0;
            push       <= 1'b0;
            fmt        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            phase      <= phase + LOG2R'(in_valid);
            push       <= dec;
            if (dec) fmt <= sat_round(wide_t'(v), D, OW);
            ovf_sticky <= (push && full && !y_ready) || (ovf_sticky && !clr_ovf);
        end
    end

    iir_fifo_fwft #(.DEPTH(DEPTH), .OW(OW)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (fmt),
        .pop     (y_ready),
        .dout    (y_out),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    assign y_valid = !empty;
endmodule

// File: tb/tb_iir_decim_out.sv
// tb_iir_decim_out: table vectors, hand sequences and random traffic checked
// against a queue-based model of decimation, rounding and the output buffer.
module tb_iir_decim_out;
    localparam int W     = 14;
    localparam int OW    = 12;
    localparam int LOG2R = 2;
    localparam int R     = 4;
    localparam int DEPTH = 4;
    localparam int D     = 3;

    typedef struct {
        int x;
        int y;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          y_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [W:0]    x_in = '0;
    logic [OW-1:0] y_out;
    logic          y_valid;
    logic [2:0]    fifo_level;
    logic          ovf_sticky;

    int n_vec = 0;
    int n_err = 0;
    int vcount = 0;
    int q[$];
    int frame[$];
    bit pend = 1'b0;
    int pend_val = 0;
    bit m_ovf = 1'b0;

    iir_decim_out #(.LOG2R(LOG2R), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x_in       (x_in),
        .in_valid   (in_valid),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .fifo_level (fifo_level),
        .ovf_sticky (ovf_sticky),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic int floordiv(int a, int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int expect_of(input int f[$]);
        int s, r;
        s = 0;
        foreach (f[i]) s += f[i];
`ifdef IIR_DECIM_AVG_EN
        r = floordiv(floordiv(s, R) + 2 ** (D - 1), 2 ** D);
`else
        r = floordiv(f[R-1] + 2 ** (D - 1), 2 ** D);
`endif
        return (r > 2 ** (OW - 1) - 1) ? 2 ** (OW - 1) - 1 : (r < -(2 ** (OW - 1))) ? -(2 ** (OW - 1)) : r;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, novf;
        pop  = q.size() > 0 && y_ready;
        novf = 1'b0;
        if (pop) void'(q.pop_front());
        if (pend) begin
            if (q.size() < DEPTH) q.push_back(pend_val);
            else novf = 1'b1;
        end
        m_ovf = novf ? 1'b1 : clr_ovf ? 1'b0 : m_ovf;
        pend  = 1'b0;
        if (in_valid) begin
            frame.push_back(int'($signed(x_in)));
            if (frame.size() == R) begin
                pend     = 1'b1;
                pend_val = expect_of(frame);
                frame.delete();
            end
        end
    endtask

    task automatic step(input int x, input bit v, input bit rdy, input bit clr);
        x_in     = (W+1)'(x);
        in_valid = v;
        y_ready  = rdy;
        clr_ovf  = clr;
        @(posedge clk);
        model_edge();
        #1;
        chk("y_valid", y_valid, q.size() > 0);
        chk("y_out", $signed(y_out), (q.size() > 0) ? q[0] : 0);
        chk("fifo_level", fifo_level, q.size());
        chk("ovf_sticky", ovf_sticky, m_ovf);
        if (y_valid) vcount++;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        y_ready  = 1'b0;
        clr_ovf  = 1'b0;
        #2;
        q.delete();
        frame.delete();
        pend  = 1'b0;
        m_ovf = 1'b0;
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_out", $signed(y_out), 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf_sticky, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t tbl[5];
        int ramp_y;
        tbl = '{'{100, 13}, '{16383, 2047}, '{-16384, -2048}, '{-5, -1}, '{3, 0}};
`ifdef IIR_DECIM_AVG_EN
        ramp_y = 2;
`else
        ramp_y = 3;
`endif
        do_reset();

        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            step(100, 1, 1, 0);
            if (i == 3) chk("t1_lat_early", y_valid, 0);
            if (i == 4) begin
                chk("t1_lat_valid", y_valid, 1);
                chk("t1_value", $signed(y_out), 13);
            end
        end
        chk("t1_rate", vcount, 4);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < R; k++) step(tbl[i].x, 1, 0, 0);
            step(0, 0, 0, 0);
            chk("tbl_valid", y_valid, 1);
            chk("tbl_y", $signed(y_out), tbl[i].y);
            step(0, 0, 1, 0);
            chk("tbl_drained", y_valid, 0);
        end

        for (int k = 0; k < 5; k++)
            for (int j = 0; j < R; j++) step(80 * (k + 1), 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("bp_level", fifo_level, 4);
        chk("bp_ovf", ovf_sticky, 1);
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", $signed(y_out), 10 * (k + 1));
            step(0, 0, 1, 0);
        end
        chk("bp_empty", fifo_level, 0);
        chk("bp_ovf_held", ovf_sticky, 1);
        step(0, 0, 0, 1);
        chk("bp_clr", ovf_sticky, 0);

        vcount = 0;
        for (int i = 0; i < 32; i++) step(100, (i % 2) == 0, 1, 0);
        chk("gap_rate", vcount, 4);
        step(0, 0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            step(8 * (i % 4), 1, 1, 0);
            if (i == 4) chk("ramp_y", $signed(y_out), ramp_y);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        for (int i = 0; i < 10; i++) step(100, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_rst_level", fifo_level, 2);
        do_reset();
        for (int i = 0; i < R; i++) step(100, 1, 0, 0);
        chk("post_rst_early", y_valid, 0);
        step(0, 0, 0, 0);
        chk("post_rst_valid", y_valid, 1);
        chk("post_rst_y", $signed(y_out), 13);
        step(0, 0, 1, 0);

        for (int i = 0; i < 400; i++)
            step(int'($urandom_range(0, 32767)) - 16384, 1'($urandom_range(0, 1)),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
